// File: rtl/wb_stream_fifo_slave.sv
// wb_stream_fifo_slave: pipelined Wishbone responder bridging a TX and an RX word FIFO to valid/ready streams.
module wb_stream_fifo_slave #(
  parameter int DEPTH = 16,
  parameter int ADR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] wb_adr,
  input  logic [31:0]      wb_dat_w,
  output logic [31:0]      wb_dat_r,
  input  logic [3:0]       wb_sel,
  output logic             wb_stall,
  input  logic             wb_cyc,
  input  logic             wb_stb,
  input  logic             wb_we,
  output logic             wb_ack,
  output logic             wb_err,
  output logic [31:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [31:0]      rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             irq_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [LW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [1:0]    flags_q, flags_d, irq_en_q, irq_en_d;
  logic          irq_q, irq_d, ack_q, ack_d, err_q, err_d;
  logic [31:0]   dat_q, dat_d, rdata, status;
  logic          acc, wr, rd, a_data, a_stat, a_ctrl, a_flag;
  logic          tx_full, tx_empty, rx_full, rx_empty, tx_flush, rx_flush;
  logic          tx_ovf, rx_udf, tx_push, tx_pop, rx_push, rx_pop;
  logic          unused_sel;
  assign unused_sel = ^wb_sel;
  always_comb begin
    acc      = wb_cyc & wb_stb;
    wr       = acc & wb_we;
    rd       = acc & !wb_we;
    a_data   = wb_adr == ADR_W'(0);
    a_stat   = wb_adr == ADR_W'(1);
    a_ctrl   = wb_adr == ADR_W'(2);
    a_flag   = wb_adr == ADR_W'(3);
    tx_full  = tx_cnt_q == LW'(DEPTH);
    tx_empty = tx_cnt_q == '0;
    rx_full  = rx_cnt_q == LW'(DEPTH);
    rx_empty = rx_cnt_q == '0;
    tx_flush = wr & a_ctrl & wb_dat_w[0];
    rx_flush = wr & a_ctrl & wb_dat_w[1];
    tx_ovf   = wr & a_data & tx_full;
    rx_udf   = rd & a_data & rx_empty;
    tx_push  = wr & a_data & !tx_full;
    tx_pop   = !tx_empty & tx_ready & !tx_flush;
    rx_push  = rx_valid & rx_ready & !rx_flush;
    rx_pop   = rd & a_data & !rx_empty;
    status   = {4'b0, rx_empty, rx_full, tx_empty, tx_full, 8'(tx_cnt_q), 8'b0, 8'(rx_cnt_q)};
    rdata    = a_data ? (rx_empty ? 32'b0 : rx_mem[rx_rp_q]) :
               a_stat ? status :
               a_ctrl ? {22'b0, irq_en_q, 8'b0} :
               a_flag ? {30'b0, flags_q} : 32'b0;
    tx_wp_d  = tx_flush ? '0 : tx_wp_q + PW'(tx_push);
    tx_rp_d  = tx_flush ? '0 : tx_rp_q + PW'(tx_pop);
    tx_cnt_d = tx_flush ? '0 : tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
    rx_wp_d  = rx_flush ? '0 : rx_wp_q + PW'(rx_push);
    rx_rp_d  = rx_flush ? '0 : rx_rp_q + PW'(rx_pop);
    rx_cnt_d = rx_flush ? '0 : rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    // W1C first, then OR in new events so a same-cycle set wins
    flags_d  = (flags_q & ~({2{wr & a_flag}} & wb_dat_w[1:0])) | {rx_udf, tx_ovf};
    irq_en_d = (wr & a_ctrl) ? wb_dat_w[9:8] : irq_en_q;
    irq_d    = |(flags_q & irq_en_q);
    err_d    = tx_ovf | rx_udf;
    ack_d    = acc & !err_d;
    dat_d    = rd ? rdata : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      flags_q  <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      flags_q  <= flags_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= wb_dat_w;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end
  assign tx_data  = tx_mem[tx_rp_q];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full & !rst;
  assign wb_stall = 1'b0;
  assign wb_ack   = ack_q & wb_cyc;
  assign wb_err   = err_q & wb_cyc;
  assign wb_dat_r = dat_q;
  assign irq_out  = irq_q;
endmodule

// File: tb/tb_wb_stream_fifo_slave.sv
// tb_wb_stream_fifo_slave: directed vector table plus hand-written corner sequences.
module tb_wb_stream_fifo_slave;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] wb_adr = '0, wb_sel = 4'hF;
  logic [31:0] wb_dat_w = '0, wb_dat_r, tx_data, rx_data = '0;
  logic wb_stall, wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0, wb_ack, wb_err;
  logic tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready, irq_out;
  int n_cmp = 0, n_bad = 0;
  wb_stream_fifo_slave #(.DEPTH(DEPTH), .ADR_W(4)) dut (
    .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_sel(wb_sel), .wb_stall(wb_stall), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_ack(wb_ack), .wb_err(wb_err), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq_out(irq_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [1:0]  ae;
    logic [31:0] rd;
  } vec_t;
  vec_t tv[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      output logic ack, output logic err, output logic [31:0] rd);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat;
    @(posedge clk); #1;
    ack = wb_ack; err = wb_err; rd = wb_dat_r;
    wb_stb = 1'b0;
  endtask
  task automatic idle();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic acc_chk(input string nm, input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [1:0] ae, input logic [31:0] exp_rd);
    logic a, e;
    logic [31:0] r;
    xfer(we, adr, dat, a, e, r);
    chk({nm, " ack/err"}, {30'b0, a, e}, {30'b0, ae});
    chk({nm, " dat_r"}, r, exp_rd);
  endtask
  task automatic rx_push(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic a, e;
    logic [31:0] r;
    int n_ack;
    tv[0]  = '{1'b0, 4'd1, 32'h0,        2'b10, 32'h0A00_0000};
    tv[1]  = '{1'b1, 4'd0, 32'h11,       2'b10, 32'h0};
    tv[2]  = '{1'b1, 4'd0, 32'h22,       2'b10, 32'h0};
    tv[3]  = '{1'b1, 4'd0, 32'h33,       2'b10, 32'h0};
    tv[4]  = '{1'b0, 4'd1, 32'h0,        2'b10, 32'h0803_0000};
    tv[5]  = '{1'b1, 4'd2, 32'h300,      2'b10, 32'h0};
    tv[6]  = '{1'b0, 4'd2, 32'h0,        2'b10, 32'h300};
    tv[7]  = '{1'b1, 4'd2, 32'h0,        2'b10, 32'h0};
    tv[8]  = '{1'b0, 4'd2, 32'h0,        2'b10, 32'h0};
    tv[9]  = '{1'b0, 4'd5, 32'h0,        2'b10, 32'h0};
    tv[10] = '{1'b1, 4'd7, 32'hFFFF_FFFF, 2'b10, 32'h0};
    tv[11] = '{1'b0, 4'd3, 32'h0,        2'b10, 32'h0};
    tv[12] = '{1'b0, 4'd0, 32'h0,        2'b01, 32'h0};
    tv[13] = '{1'b0, 4'd3, 32'h0,        2'b10, 32'h2};
    tv[14] = '{1'b1, 4'd3, 32'h2,        2'b10, 32'h0};
    tv[15] = '{1'b0, 4'd3, 32'h0,        2'b10, 32'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst rx_ready", {31'b0, rx_ready}, 32'h0);
    chk("rst tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst ack/err/irq", {29'b0, wb_ack, wb_err, irq_out}, 32'h0);
    chk("rst dat_r", wb_dat_r, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst rx_ready", {31'b0, rx_ready}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      xfer(tv[i].we, tv[i].adr, tv[i].dat, a, e, r);
      chk($sformatf("vec%0d ack/err", i), {30'b0, a, e}, {30'b0, tv[i].ae});
      chk($sformatf("vec%0d dat_r", i), r, tv[i].rd);
    end
    idle();
    chk("tx_valid loaded", {31'b0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx drain %0d", i), tx_data, 32'h11 * (i + 1));
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    chk("tx drained valid", {31'b0, tx_valid}, 32'h0);
    n_ack = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      xfer(1'b1, 4'd0, 32'h100 + i, a, e, r);
      if (i < DEPTH) n_ack += int'(a);
    end
    chk("ovf ack count", n_ack, DEPTH);
    chk("ovf last resp", {30'b0, a, e}, 32'h1);
    acc_chk("flags ovf", 1'b0, 4'd3, 32'h0, 2'b10, 32'h1);
    acc_chk("irq_en wr", 1'b1, 4'd2, 32'h100, 2'b10, 32'h0);
    chk("irq registered lag", {31'b0, irq_out}, 32'h0);
    idle();
    chk("irq set", {31'b0, irq_out}, 32'h1);
    acc_chk("flags w1c", 1'b1, 4'd3, 32'h1, 2'b10, 32'h0);
    idle();
    chk("irq cleared", {31'b0, irq_out}, 32'h0);
    acc_chk("tx flush", 1'b1, 4'd2, 32'h101, 2'b10, 32'h0);
    acc_chk("status after flush", 1'b0, 4'd1, 32'h0, 2'b10, 32'h0A00_0000);
    idle();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'd1;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    #1;
    chk("dropped cyc no ack", {31'b0, wb_ack}, 32'h0);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("rx_ready before %0d", i), {31'b0, rx_ready}, 32'h1);
      rx_push(32'hA0 + i);
    end
    chk("rx_ready full", {31'b0, rx_ready}, 32'h0);
    acc_chk("status rx full", 1'b0, 4'd1, 32'h0, 2'b10, 32'h0600_0010);
    for (int i = 0; i < DEPTH; i++)
      acc_chk($sformatf("rx pop %0d", i), 1'b0, 4'd0, 32'h0, 2'b10, 32'hA0 + i);
    acc_chk("rx underflow", 1'b0, 4'd0, 32'h0, 2'b01, 32'h0);
    acc_chk("flags udf", 1'b0, 4'd3, 32'h0, 2'b10, 32'h2);
    acc_chk("flags clr", 1'b1, 4'd3, 32'h3, 2'b10, 32'h0);
    idle();
    for (int i = 0; i < 5; i++) rx_push(32'hB0 + i);
    rx_data = 32'hB5; rx_valid = 1'b1;
    xfer(1'b0, 4'd0, 32'h0, a, e, r);
    rx_valid = 1'b0;
    chk("simul pop data", r, 32'hB0);
    acc_chk("simul level", 1'b0, 4'd1, 32'h0, 2'b10, 32'h0200_0005);
    for (int i = 1; i < 6; i++)
      acc_chk($sformatf("simul order %0d", i), 1'b0, 4'd0, 32'h0, 2'b10, 32'hB0 + i);
    for (int k = 0; k < 3; k++) begin
      idle();
      for (int i = 0; i < 12; i++) rx_push(32'hC00 + k * 16 + i);
      for (int i = 0; i < 12; i++)
        acc_chk($sformatf("wrap r%0d i%0d", k, i), 1'b0, 4'd0, 32'h0, 2'b10, 32'hC00 + k * 16 + i);
    end
    acc_chk("tx fill 1", 1'b1, 4'd0, 32'h1, 2'b10, 32'h0);
    acc_chk("tx fill 2", 1'b1, 4'd0, 32'h2, 2'b10, 32'h0);
    tx_ready = 1'b1;
    acc_chk("flush vs pop", 1'b1, 4'd2, 32'h101, 2'b10, 32'h0);
    chk("flush tx_valid", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    idle();
    rx_push(32'hD0);
    rx_push(32'hD1);
    rx_data = 32'hEE; rx_valid = 1'b1;
    acc_chk("flush vs push", 1'b1, 4'd2, 32'h102, 2'b10, 32'h0);
    rx_valid = 1'b0;
    acc_chk("status both flushed", 1'b0, 4'd1, 32'h0, 2'b10, 32'h0A00_0000);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 4'd0; wb_dat_w = 32'h77;
    @(posedge clk); #1;
    chk("burst ack pre-rst", {31'b0, wb_ack}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst drops ack", {30'b0, wb_ack, wb_err}, 32'h0);
    chk("rst rx_ready mid", {31'b0, rx_ready}, 32'h0);
    chk("rst tx_valid mid", {31'b0, tx_valid}, 32'h0);
    rst = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    @(posedge clk); #1;
    chk("no ack after rst", {31'b0, wb_ack}, 32'h0);
    acc_chk("status after rst", 1'b0, 4'd1, 32'h0, 2'b10, 32'h0A00_0000);
    acc_chk("ctrl after rst", 1'b0, 4'd2, 32'h0, 2'b10, 32'h0);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
